// File: rtl/dp_core_seq_if.sv
// rtl/dp_core_seq_if.sv - request/response bundle between a sequencer client and dp_core_seq
interface dp_core_seq_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              start;
    logic [2:0]        op_mode;
    logic [2:0]        ALU_OP;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic              busy;
    logic              done;
    logic              err;
    logic              ZF;
    logic              OF;
    logic [DATA_W-1:0] F;
    logic [DATA_W-1:0] R_Data_A;
    logic [DATA_W-1:0] R_Data_B;
    logic [DATA_W-1:0] M_R_Data;
    logic [DATA_W-1:0] W_Data;

    modport master (
        output start, op_mode, ALU_OP, rs, rt, rd, imm,
        input  busy, done, err, ZF, OF, F, R_Data_A, R_Data_B, M_R_Data, W_Data
    );

    modport slave (
        input  start, op_mode, ALU_OP, rs, rt, rd, imm,
        output busy, done, err, ZF, OF, F, R_Data_A, R_Data_B, M_R_Data, W_Data
    );
endinterface

// File: rtl/dp_core_seq.sv
// rtl/dp_core_seq.sv - register file + ALU + data RAM executing one micro-op per start/done handshake
module dp_core_seq #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 6
) (
    input  logic          clk,
    input  logic          Reset,
    dp_core_seq_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MEM, S_WB} state_t;

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_SWAP  = 3'b011;
    localparam logic [2:0] OP_LOADI = 3'b100;
    localparam logic [2:0] ALU_ADD  = 3'b100;

    state_t state, state_nx;

    logic [2:0]        op_q;
    logic [2:0]        alu_op_q;
    logic [REG_AW-1:0] rs_q, rt_q, rd_q;
    logic [DATA_W-1:0] imm_q;

    logic [DATA_W-1:0] regs [2**REG_AW];
    logic [DATA_W-1:0] ram  [2**MEM_AW];

    logic [2:0]        alu_sel;
    logic [DATA_W-1:0] a, b, sum, diff, alu_f;
    logic              alu_of;
    logic              flag_upd, mem_rd, mem_wr, reg_we, illegal;
    logic [MEM_AW-1:0] addr;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_READ;
            S_READ:  state_nx = S_EXEC;
            S_EXEC:  state_nx = S_MEM;
            S_MEM:   state_nx = S_WB;
            S_WB:    state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        illegal     = (op_q > OP_LOADI);
        reg_we      = (state == S_WB) && !illegal && (op_q != OP_STORE);
        bus.busy    = (state != S_IDLE);
        bus.done    = (state == S_WB);
        bus.err     = (state == S_WB) && illegal;
        bus.W_Data  = '0;
        if (state == S_WB) begin
            case (op_q)
                OP_ALU:           bus.W_Data = bus.F;
                OP_LOAD, OP_SWAP: bus.W_Data = bus.M_R_Data;
                OP_LOADI:         bus.W_Data = imm_q;
                default:          bus.W_Data = '0;
            endcase
        end
    end

    // Memory-class ops reuse the adder for address generation, whatever ALU_OP says.
    always_comb begin
        a        = bus.R_Data_A;
        b        = bus.R_Data_B;
        alu_sel  = (op_q == OP_ALU) ? alu_op_q : ALU_ADD;
        sum      = a + b;
        diff     = a - b;
        alu_of   = 1'b0;
        flag_upd = (op_q <= OP_SWAP);
        case (alu_sel)
            3'b000: alu_f = a & b;
            3'b001: alu_f = a | b;
            3'b010: alu_f = a ^ b;
            3'b011: alu_f = ~(a | b);
            3'b100: begin
                alu_f  = sum;
                alu_of = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            3'b101: begin
                alu_f  = diff;
                alu_of = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            3'b110: alu_f = ($signed(a) < $signed(b)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
            default: alu_f = b << a[4:0];
        endcase
        addr   = bus.F[MEM_AW-1:0];
        mem_rd = (state == S_MEM) && ((op_q == OP_LOAD) || (op_q == OP_SWAP));
        mem_wr = (state == S_MEM) && ((op_q == OP_STORE) || (op_q == OP_SWAP));
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            op_q     <= '0;
            alu_op_q <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
        end else if (state == S_IDLE && bus.start) begin
            op_q     <= bus.op_mode;
            alu_op_q <= bus.ALU_OP;
            rs_q     <= bus.rs;
            rt_q     <= bus.rt;
            rd_q     <= bus.rd;
            imm_q    <= bus.imm;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            bus.R_Data_A <= '0;
            bus.R_Data_B <= '0;
            bus.F        <= '0;
            bus.ZF       <= 1'b0;
            bus.OF       <= 1'b0;
            bus.M_R_Data <= '0;
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else begin
            if (state == S_READ) begin
                bus.R_Data_A <= regs[rs_q];
                bus.R_Data_B <= regs[rt_q];
            end
            if (state == S_EXEC && flag_upd) begin
                bus.F  <= alu_f;
                bus.ZF <= (alu_f == '0);
                bus.OF <= alu_of;
            end
            if (mem_rd) bus.M_R_Data <= ram[addr];
            if (reg_we) regs[rd_q] <= bus.W_Data;
        end
    end

    // RAM keeps its contents across reset; the read above sees the pre-write word on SWAP.
    always_ff @(posedge clk) begin
        if (mem_wr) ram[addr] <= bus.R_Data_B;
    end
endmodule

// File: tb/tb_dp_core_seq.sv
// tb/tb_dp_core_seq.sv - directed self-checking bench for dp_core_seq against a behavioural model
module tb_dp_core_seq;
    logic clk = 1'b0;
    logic Reset = 1'b1;
    always #5 clk = ~clk;

    dp_core_seq_if #(.DATA_W(32), .REG_AW(5)) bus ();

    dp_core_seq #(.DATA_W(32), .REG_AW(5), .MEM_AW(6)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int pass_cnt = 0;
    int total    = 0;
    int done_seen = 0;

    logic [31:0] mreg [32];
    logic [31:0] mmem [int];
    logic [31:0] mF, mM;
    logic        mZF, mOF;

    logic        exp_armed = 1'b0;
    logic        exp_err, exp_we;
    logic [31:0] exp_W;
    logic [31:0] cap_F, cap_W, cap_M;
    logic        cap_ZF, cap_OF, cap_err;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        mF = '0; mM = '0; mZF = 1'b0; mOF = 1'b0;
    endtask

    task automatic model_alu(input logic [2:0] alu, input logic [31:0] a, input logic [31:0] b);
        longint r;
        mOF = 1'b0;
        case (alu)
            3'd0: mF = a & b;
            3'd1: mF = a | b;
            3'd2: mF = a ^ b;
            3'd3: mF = ~(a | b);
            3'd4: begin
                r = longint'($signed(a)) + longint'($signed(b));
                mF = 32'(r);
                mOF = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd5: begin
                r = longint'($signed(a)) - longint'($signed(b));
                mF = 32'(r);
                mOF = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd6: mF = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: mF = b << a[4:0];
        endcase
        mZF = (mF == 32'd0);
    endtask

    always @(negedge clk) begin
        if (bus.done) begin
            done_seen++;
            if (exp_armed) begin
                chk("err", {31'd0, bus.err}, {31'd0, exp_err});
                chk("busy_in_wb", {31'd0, bus.busy}, 32'd1);
                chk("F", bus.F, mF);
                chk("ZF", {31'd0, bus.ZF}, {31'd0, mZF});
                chk("OF", {31'd0, bus.OF}, {31'd0, mOF});
                chk("M_R_Data", bus.M_R_Data, mM);
                if (exp_we) chk("W_Data", bus.W_Data, exp_W);
                cap_F = bus.F; cap_W = bus.W_Data; cap_M = bus.M_R_Data;
                cap_ZF = bus.ZF; cap_OF = bus.OF; cap_err = bus.err;
                exp_armed = 1'b0;
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [2:0] alu, input logic [4:0] s,
                          input logic [4:0] t, input logic [4:0] d, input logic [31:0] im,
                          input bit poke);
        logic [31:0] a, b;
        logic [5:0]  addr;
        int cycles;
        @(negedge clk);
        bus.op_mode = op; bus.ALU_OP = alu; bus.rs = s; bus.rt = t; bus.rd = d; bus.imm = im;
        bus.start = 1'b1;
        a = mreg[s]; b = mreg[t];
        exp_err = 1'b0; exp_we = 1'b0; exp_W = '0;
        case (op)
            3'd0: begin model_alu(alu, a, b); exp_W = mF; exp_we = 1'b1; end
            3'd1, 3'd2, 3'd3: begin
                model_alu(3'd4, a, b);
                addr = mF[5:0];
                if (op != 3'd2) begin mM = mmem[int'(addr)]; exp_W = mM; exp_we = 1'b1; end
                if (op != 3'd1) mmem[int'(addr)] = b;
            end
            3'd4: begin exp_W = im; exp_we = 1'b1; end
            default: exp_err = 1'b1;
        endcase
        if (exp_we) mreg[d] = exp_W;
        exp_armed = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cycles = 1;
        while (!bus.done && cycles < 10) begin
            if (poke && cycles == 2) begin bus.start = 1'b1; bus.rd = 5'd31; bus.op_mode = 3'b101; end
            if (poke && cycles == 3) bus.start = 1'b0;
            @(negedge clk);
            cycles++;
        end
        chk("latency", cycles, 4);
        if (poke) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_wb", {31'd0, bus.busy}, 32'd0);
        exp_armed = 1'b0;
    endtask

    initial begin
        int d0;
        bus.start = 1'b0; bus.op_mode = '0; bus.ALU_OP = '0;
        bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.imm = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_F", bus.F, 32'd0);
        chk("rst_W", bus.W_Data, 32'd0);
        chk("rst_M", bus.M_R_Data, 32'd0);
        Reset = 1'b0;

        run_op(3'd4, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_FFFF, 1'b0);
        run_op(3'd4, 3'd0, 5'd0, 5'd0, 5'd1, 32'hFFFF_0000, 1'b0);
        run_op(3'd0, 3'd4, 5'd0, 5'd1, 5'd2, 32'd0, 1'b0);
        chk("t1_F", cap_F, 32'hFFFF_FFFF);
        chk("t1_W", cap_W, 32'hFFFF_FFFF);
        chk("t1_ZF_OF", {30'd0, cap_ZF, cap_OF}, 32'd0);

        run_op(3'd4, 3'd0, 5'd0, 5'd0, 5'd3, 32'hAAAA_AA80, 1'b0);
        run_op(3'd4, 3'd0, 5'd0, 5'd0, 5'd4, 32'h0000_0029, 1'b0);
        run_op(3'd2, 3'd1, 5'd3, 5'd4, 5'd0, 32'd0, 1'b0);
        run_op(3'd1, 3'd7, 5'd3, 5'd4, 5'd5, 32'd0, 1'b0);
        chk("t2_M", cap_M, 32'h0000_0029);

        run_op(3'd4, 3'd0, 5'd0, 5'd0, 5'd6, 32'h7FFF_FFFF, 1'b0);
        run_op(3'd4, 3'd0, 5'd0, 5'd0, 5'd7, 32'h0000_0001, 1'b0);
        run_op(3'd0, 3'd4, 5'd6, 5'd7, 5'd13, 32'd0, 1'b0);
        chk("t3_add_F", cap_F, 32'h8000_0000);
        chk("t3_add_flags", {30'd0, cap_ZF, cap_OF}, 32'd1);
        run_op(3'd0, 3'd5, 5'd6, 5'd6, 5'd14, 32'd0, 1'b0);
        chk("t3_sub_F", cap_F, 32'd0);
        chk("t3_sub_flags", {30'd0, cap_ZF, cap_OF}, 32'd2);
        run_op(3'd0, 3'd6, 5'd1, 5'd7, 5'd15, 32'd0, 1'b0);
        chk("slt_neg", cap_W, 32'd1);
        run_op(3'd0, 3'd7, 5'd7, 5'd0, 5'd16, 32'd0, 1'b0);
        chk("sll", cap_W, 32'h0001_FFFE);
        run_op(3'd0, 3'd3, 5'd0, 5'd1, 5'd17, 32'd0, 1'b0);
        chk("nor", cap_W, 32'd0);

        run_op(3'd4, 3'd0, 5'd0, 5'd0, 5'd9, 32'h0000_0029, 1'b0);
        run_op(3'd4, 3'd0, 5'd0, 5'd0, 5'd10, 32'h0000_0100, 1'b0);
        run_op(3'd3, 3'd2, 5'd9, 5'd10, 5'd8, 32'd0, 1'b0);
        chk("t4_swap_W", cap_W, 32'h0000_0029);
        run_op(3'd1, 3'd0, 5'd9, 5'd11, 5'd12, 32'd0, 1'b0);
        chk("t4_load_M", cap_M, 32'h0000_0100);

        d0 = done_seen;
        run_op(3'd0, 3'd2, 5'd0, 5'd1, 5'd18, 32'd0, 1'b1);
        repeat (4) @(negedge clk);
        chk("poke_one_done", done_seen - d0, 1);
        chk("poke_idle", {31'd0, bus.busy}, 32'd0);
        run_op(3'd0, 3'd1, 5'd18, 5'd31, 5'd19, 32'd0, 1'b0);
        chk("poke_r18", cap_W, 32'hFFFF_FFFF);

        @(negedge clk);
        bus.op_mode = 3'd0; bus.ALU_OP = 3'd4; bus.rs = 5'd0; bus.rt = 5'd1; bus.rd = 5'd20;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_F", bus.F, 32'd0);
        model_reset();
        @(negedge clk);
        Reset = 1'b0;
        run_op(3'd0, 3'd1, 5'd20, 5'd20, 5'd21, 32'd0, 1'b0);
        chk("abort_r20", cap_W, 32'd0);

        run_op(3'd4, 3'd0, 5'd0, 5'd0, 5'd1, 32'd41, 1'b0);
        run_op(3'd1, 3'd0, 5'd1, 5'd0, 5'd2, 32'd0, 1'b0);
        chk("ram_kept", cap_M, 32'h0000_0100);
        run_op(3'd5, 3'd5, 5'd1, 5'd1, 5'd2, 32'hDEAD_BEEF, 1'b0);
        chk("illegal_err", {31'd0, cap_err}, 32'd1);
        chk("illegal_F", cap_F, 32'd41);
        run_op(3'd0, 3'd1, 5'd2, 5'd2, 5'd3, 32'd0, 1'b0);
        chk("illegal_r2", cap_W, 32'h0000_0100);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
